reg_write_port: RTL and testbench

REG_WRITE_PORT -- requirements
Module: reg_write_port

---
 rtl/cpu_bus_pkg.sv | 14 +
 rtl/sel_decoder5_32.sv | 24 ++
 rtl/reg_write_port.sv | 105 ++++++++++
 tb/tb_reg_write_port.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared CPU register-bus constants and the write-queue entry type.
// Used by reg_write_port and its select decoder.
package cpu_bus_pkg;

    localparam int REG_COUNT  = 32;
    localparam int SEL_W      = 5;
    localparam int DEF_DATA_W = 32;

    typedef struct packed {
        logic [SEL_W-1:0]      sel;
        logic [DEF_DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/sel_decoder5_32.sv
// 5-bit register index to 32-bit one-hot load enable, gated by i_en.
module sel_decoder5_32
    import cpu_bus_pkg::*;
(
    input  logic                 i_en,
    input  logic [SEL_W-1:0]     i_sel,
    output logic [REG_COUNT-1:0] o_onehot
);

    logic [REG_COUNT-1:0] w_one;

    assign w_one = {{(REG_COUNT-1){1'b0}}, 1'b1};

    // Shift a single set bit into position; all-zero when disabled
    always_comb begin
        o_onehot = {REG_COUNT{1'b0}};
        if (i_en) begin
            o_onehot = w_one << i_sel;
        end else begin
            o_onehot = {REG_COUNT{1'b0}};
        end
    end

endmodule

// File: rtl/reg_write_port.sv
// Register write port: queues (sel, data) requests and retires one per cycle as a
// one-hot load_en pulse. Optional macro REG_WRITE_R0_ZERO_EN suppresses writes to register 0.
module reg_write_port
    import cpu_bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [SEL_W-1:0]     wr_sel,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 hold,
    output logic [REG_COUNT-1:0] load_en,
    output logic [DATA_W-1:0]    load_data,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [SEL_W-1:0]     r_sel_q  [DEPTH];
    logic [DATA_W-1:0]    r_data_q [DEPTH];
    logic [IDX_W-1:0]     r_wr_ptr;
    logic [IDX_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [REG_COUNT-1:0] r_load_en;
    logic [DATA_W-1:0]    r_load_data;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_dec_en;
    logic [SEL_W-1:0]     w_head_sel;
    logic [DATA_W-1:0]    w_head_data;
    logic [REG_COUNT-1:0] w_onehot;

    // Ready depends only on the registered count, so hold/wr_valid never reach it
    assign wr_ready    = (r_count < DEPTH_C);
    assign w_push      = wr_valid & wr_ready;
    assign w_pop       = (r_count != {CNT_W{1'b0}}) & ~hold;
    assign w_head_sel  = r_sel_q[r_rd_ptr];
    assign w_head_data = r_data_q[r_rd_ptr];

`ifdef REG_WRITE_R0_ZERO_EN
    assign w_dec_en = w_pop & (w_head_sel != {SEL_W{1'b0}});
`else
    assign w_dec_en = w_pop;
`endif

    sel_decoder5_32 u_dec (
        .i_en     (w_dec_en),
        .i_sel    (w_head_sel),
        .o_onehot (w_onehot)
    );

    // Queue storage; only written on an accepted request
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sel_q[r_wr_ptr]  <= wr_sel;
            r_data_q[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wr_ptr <= {IDX_W{1'b0}};
            r_rd_ptr <= {IDX_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + IDX_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + IDX_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered load outputs: pulse on pop, data held between pops
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_load_en   <= {REG_COUNT{1'b0}};
            r_load_data <= {DATA_W{1'b0}};
        end else if (w_pop) begin
            r_load_en   <= w_onehot;
            r_load_data <= w_head_data;
        end else begin
            r_load_en   <= {REG_COUNT{1'b0}};
        end
    end

    assign load_en   = r_load_en;
    assign load_data = r_load_data;
    assign busy      = (r_count != {CNT_W{1'b0}}) | (r_load_en != {REG_COUNT{1'b0}});

endmodule

// File: tb/tb_reg_write_port.sv
// Directed self-checking bench for reg_write_port (DEPTH=2, DATA_W=32).
module tb_reg_write_port;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [4:0]  wr_sel = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic        hold = 1'b0;
    logic [31:0] load_en;
    logic [31:0] load_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    reg_write_port #(.DATA_W(32), .DEPTH(2)) dut (
        .clk       (clk),
        .clr       (clr),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .hold      (hold),
        .load_en   (load_en),
        .load_data (load_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          issued;
        int          rx;
        int          cyc;
        logic        acc;
        logic        h;
        logic [31:0] exp_en;

        // reset state while clr is high
        #12;
        check_eq("rst_load_en", 64'(load_en), 64'h0);
        check_eq("rst_load_data", 64'(load_data), 64'h0);
        check_eq("rst_busy", 64'(busy), 64'h0);
        check_eq("rst_ready", 64'(wr_ready), 64'h1);
        step();
        clr = 1'b0;

        // single write
        wr_valid = 1'b1; wr_sel = 5'd7; wr_data = 32'hDEADBEEF;
        step();
        wr_valid = 1'b0;
        check_eq("sw_accept_en", 64'(load_en), 64'h0);
        check_eq("sw_busy", 64'(busy), 64'h1);
        step();
        check_eq("sw_pulse_en", 64'(load_en), 64'h80);
        check_eq("sw_pulse_data", 64'(load_data), 64'hDEADBEEF);
        step();
        check_eq("sw_end_en", 64'(load_en), 64'h0);
        check_eq("sw_hold_data", 64'(load_data), 64'hDEADBEEF);
        check_eq("sw_idle_busy", 64'(busy), 64'h0);

        // back-to-back writes
        wr_valid = 1'b1; wr_sel = 5'd1; wr_data = 32'h11;
        check_eq("b2b_ready1", 64'(wr_ready), 64'h1);
        step();
        wr_sel = 5'd2; wr_data = 32'h22;
        check_eq("b2b_ready2", 64'(wr_ready), 64'h1);
        step();
        check_eq("b2b_en1", 64'(load_en), 64'h2);
        wr_sel = 5'd3; wr_data = 32'h33;
        check_eq("b2b_ready3", 64'(wr_ready), 64'h1);
        step();
        check_eq("b2b_en2", 64'(load_en), 64'h4);
        wr_valid = 1'b0;
        step();
        check_eq("b2b_en3", 64'(load_en), 64'h8);
        check_eq("b2b_data3", 64'(load_data), 64'h33);
        step();
        check_eq("b2b_end", 64'(load_en), 64'h0);

        // stall with hold: two accepted, third refused until drained
        hold = 1'b1; wr_valid = 1'b1; wr_sel = 5'd10; wr_data = 32'hA0;
        step();
        wr_sel = 5'd11; wr_data = 32'hA1;
        check_eq("st_ready2", 64'(wr_ready), 64'h1);
        step();
        check_eq("st_en_a", 64'(load_en), 64'h0);
        wr_sel = 5'd12; wr_data = 32'hA2;
        check_eq("st_full_ready", 64'(wr_ready), 64'h0);
        step();
        check_eq("st_en_b", 64'(load_en), 64'h0);
        check_eq("st_still_full", 64'(wr_ready), 64'h0);
        hold = 1'b0;
        step();
        check_eq("st_pulse10", 64'(load_en), 64'h400);
        check_eq("st_data10", 64'(load_data), 64'hA0);
        check_eq("st_ready_after", 64'(wr_ready), 64'h1);
        step();
        wr_valid = 1'b0;
        check_eq("st_pulse11", 64'(load_en), 64'h800);
        step();
        check_eq("st_pulse12", 64'(load_en), 64'h1000);
        check_eq("st_data12", 64'(load_data), 64'hA2);
        step();
        check_eq("st_end_busy", 64'(busy), 64'h0);

        // register 0 write
        wr_valid = 1'b1; wr_sel = 5'd0; wr_data = 32'h1234;
        step();
        wr_valid = 1'b0;
        step();
`ifdef REG_WRITE_R0_ZERO_EN
        check_eq("r0_en", 64'(load_en), 64'h0);
`else
        check_eq("r0_en", 64'(load_en), 64'h1);
`endif
        step();
        check_eq("r0_busy", 64'(busy), 64'h0);

        // asynchronous clear mid-operation
        hold = 1'b1; wr_valid = 1'b1; wr_sel = 5'd4; wr_data = 32'h44;
        step();
        wr_sel = 5'd5; wr_data = 32'h55;
        step();
        wr_valid = 1'b0;
        check_eq("mc_full", 64'(wr_ready), 64'h0);
        #2 clr = 1'b1;
        #1;
        check_eq("mc_ready", 64'(wr_ready), 64'h1);
        check_eq("mc_en", 64'(load_en), 64'h0);
        check_eq("mc_busy", 64'(busy), 64'h0);
        #2 clr = 1'b0;
        hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("mc_no_pulse", 64'(load_en), 64'h0);
        end

        // wrap-around with random hold
        issued = 0; rx = 0; cyc = 0;
        while ((rx < 20) && (cyc < 400)) begin
            h = 1'($urandom_range(0, 1));
            hold = h;
            wr_valid = (issued < 20);
            wr_sel   = 5'(issued + 1);
            wr_data  = 32'((issued + 1) * 3);
            acc = wr_valid & wr_ready;
            step();
            cyc++;
            if (acc) issued++;
            if (h) begin
                check_eq("wr_hold_quiet", 64'(load_en), 64'h0);
            end else if (load_en != 32'h0) begin
                exp_en = 32'h1 << (rx + 1);
                check_eq("wr_en", 64'(load_en), 64'(exp_en));
                check_eq("wr_data", 64'(load_data), 64'((rx + 1) * 3));
                rx++;
            end
        end
        wr_valid = 1'b0;
        hold = 1'b0;
        check_eq("wr_all_rx", 64'(rx), 64'd20);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("wr_no_extra", 64'(load_en), 64'h0);
        end
        check_eq("wr_idle_busy", 64'(busy), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
